keypad_decoder: RTL and testbench

Scans a 4x4 matrix keypad (Pmod KYPD layout) and converts a debounced single key press into a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the 7-segment display path: its key_code/key_valid outputs feed the digit registers that drive the display decoder. It drives columns active-low, reads active-low pulled-up rows, and debounces over whole scans.

---
 rtl/keypad_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_keypad_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad scanner: drives one-cold active-low columns, samples synchronized rows,
// classifies each full scan and debounces single-key presses/releases over whole scans.
module keypad_decoder #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_ONE   = 2'd1;
    localparam logic [1:0] CLS_MULTI = 2'd2;

    // Pmod KYPD legend, indexed by {row, column}.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] count_zeros(input logic [3:0] r);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~r[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] first_zero(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [3:0]        row_meta_r;
    logic [3:0]        row_sync_r;
    logic [TICK_W-1:0] tick_r;
    logic [1:0]        col_idx_r;
    logic [3:0]        col_r;
    logic [1:0]        acc_zeros_r;
    logic [3:0]        acc_code_r;
    logic              scan_done_r;
    logic [1:0]        scan_cls_r;
    logic [3:0]        scan_code_r;
    logic [1:0]        state_r;
    logic [3:0]        cand_r;
    logic [3:0]        cnt_r;
    logic [3:0]        key_code_r;
    logic              key_valid_r;
    logic              key_held_r;

    logic              last_tick_s;
    logic [2:0]        zeros_sum_s;
    logic [1:0]        cls_s;
    logic [3:0]        code_s;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cand_nxt_s;
    logic [3:0]        cnt_nxt_s;
    logic [3:0]        code_nxt_s;
    logic              valid_nxt_s;
    logic              held_nxt_s;

    assign col       = col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
        end
    end

    // Merge this column's sample into the running scan tally.
    always_comb begin
        last_tick_s = (tick_r == TICK_LAST);
        zeros_sum_s = {1'b0, acc_zeros_r} + count_zeros(row_sync_r);
        if (zeros_sum_s == 3'd0) begin
            cls_s = CLS_NONE;
        end else if (zeros_sum_s == 3'd1) begin
            cls_s = CLS_ONE;
        end else begin
            cls_s = CLS_MULTI;
        end
        if (acc_zeros_r == 2'd1) begin
            code_s = acc_code_r;
        end else begin
            code_s = key_map(first_zero(row_sync_r), col_idx_r);
        end
    end

    // Column drive, tick timing and per-scan accumulation; the column-3 sample publishes the scan result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r      <= '0;
            col_idx_r   <= 2'd0;
            col_r       <= 4'b1110;
            acc_zeros_r <= 2'd0;
            acc_code_r  <= 4'h0;
            scan_done_r <= 1'b0;
            scan_cls_r  <= CLS_NONE;
            scan_code_r <= 4'h0;
        end else if (last_tick_s) begin
            tick_r    <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= {col_r[2:0], col_r[3]};
            if (col_idx_r == 2'd3) begin
                scan_done_r <= 1'b1;
                scan_cls_r  <= cls_s;
                scan_code_r <= code_s;
                acc_zeros_r <= 2'd0;
                acc_code_r  <= 4'h0;
            end else begin
                scan_done_r <= 1'b0;
                acc_zeros_r <= (zeros_sum_s >= 3'd2) ? 2'd2 : zeros_sum_s[1:0];
                acc_code_r  <= code_s;
            end
        end else begin
            tick_r      <= tick_r + TICK_W'(1);
            scan_done_r <= 1'b0;
        end
    end

    // Debounce FSM, stepped once per completed scan.
    always_comb begin
        state_nxt_s = state_r;
        cand_nxt_s  = cand_r;
        cnt_nxt_s   = cnt_r;
        code_nxt_s  = key_code_r;
        valid_nxt_s = 1'b0;
        held_nxt_s  = key_held_r;
        if (scan_done_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_cls_r == CLS_ONE) begin
                        state_nxt_s = ST_DEBOUNCE;
                        cand_nxt_s  = scan_code_r;
                        cnt_nxt_s   = 4'd1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_cls_r != CLS_ONE) begin
                        state_nxt_s = ST_IDLE;
                    end else if (scan_code_r != cand_r) begin
                        cand_nxt_s = scan_code_r;
                        cnt_nxt_s  = 4'd1;
                    end else if (cnt_r + 4'd1 == DEB_LAST) begin
                        state_nxt_s = ST_PRESSED;
                        code_nxt_s  = cand_r;
                        valid_nxt_s = 1'b1;
                        held_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end
                end
                ST_PRESSED: begin
                    if (scan_cls_r == CLS_NONE) begin
                        state_nxt_s = ST_RELEASE;
                        cnt_nxt_s   = 4'd1;
                    end else begin
                        state_nxt_s = ST_PRESSED;
                    end
                end
                ST_RELEASE: begin
                    if (scan_cls_r != CLS_NONE) begin
                        state_nxt_s = ST_PRESSED;
                    end else if (cnt_r + 4'd1 == DEB_LAST) begin
                        state_nxt_s = ST_IDLE;
                        held_nxt_s  = 1'b0;
                    end else begin
                        cnt_nxt_s = cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    held_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cand_r      <= 4'h0;
            cnt_r       <= 4'd0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cand_r      <= cand_nxt_s;
            cnt_r       <= cnt_nxt_s;
            key_code_r  <= code_nxt_s;
            key_valid_r <= valid_nxt_s;
            key_held_r  <= held_nxt_s;
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: directed keypad scenarios plus random key patterns,
// compared every cycle against a scan-level behavioural model.
module tb_keypad_decoder;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    // Model state: bit index of a key is row*4+column.
    logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    bit         m_held, m_pulse, cur_held;
    logic [3:0] m_code, cur_code;
    int         m_run, m_rel, m_cand;

    keypad_decoder #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row to a driven-low column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_pulse = 1'b0; m_code = 4'h0; m_run = 0; m_rel = 0; m_cand = -1;
        cur_held = 1'b0; cur_code = 4'h0;
    endtask

    // One scan's key set -> new held/code/pulse, visible one cycle into the next scan.
    task automatic model_scan(input logic [15:0] keys);
        int n, idx;
        n = $countones(keys);
        idx = -1;
        for (int b = 0; b < 16; b++) if (keys[b]) idx = b;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && idx == m_cand) m_run++;
                else begin m_cand = idx; m_run = 1; end
            end else begin
                m_run = 0;
            end
            if (m_run == D) begin
                m_pulse = 1'b1; m_held = 1'b1; m_code = key_tab[idx]; m_rel = 0; m_run = 0;
            end
        end else begin
            if (n == 0) m_rel++;
            else m_rel = 0;
            if (m_rel == D) begin m_held = 1'b0; m_run = 0; end
        end
    endtask

    task automatic run_scan(input logic [15:0] keys, input int abort_at);
        logic [3:0] exp_col;
        bit exp_valid;
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) return;
            if (i == 0) pressed = keys;
            exp_valid = 1'b0;
            if (i == 1) begin
                cur_held = m_held; cur_code = m_code; exp_valid = m_pulse; m_pulse = 1'b0;
            end
            exp_col = 4'b1111 ^ (4'b0001 << (i / 4));
            chk("col", {4'h0, col}, {4'h0, exp_col});
            chk("key_valid", {7'h0, key_valid}, {7'h0, exp_valid});
            chk("key_held", {7'h0, key_held}, {7'h0, cur_held});
            chk("key_code", {4'h0, key_code}, {4'h0, cur_code});
            if (key_valid) pulses++;
            @(negedge clk);
        end
        model_scan(keys);
    endtask

    task automatic scans(input logic [15:0] keys, input int n);
        repeat (n) run_scan(keys, 16);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_col", {4'h0, col}, 8'h0E);
        chk("rst_valid", {7'h0, key_valid}, 8'h00);
        chk("rst_held", {7'h0, key_held}, 8'h00);
        chk("rst_code", {4'h0, key_code}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] k;
        rst_n = 1'b0;
        pressed = 16'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Press '5', hold 10 scans, release.
        pulses = 0;
        scans(16'h1 << 5, 10);
        scans(16'h0, 4);
        chk("pulses_5", 8'(pulses), 8'd1);

        // Bounce 'D' for 6 scans, then hold.
        pulses = 0;
        repeat (3) begin
            scans(16'h1 << 15, 1);
            scans(16'h0, 1);
        end
        chk("pulses_bounce", 8'(pulses), 8'd0);
        scans(16'h1 << 15, 4);
        scans(16'h0, 4);
        chk("pulses_D", 8'(pulses), 8'd1);

        // '1' and 'A' together, then only '1'.
        pulses = 0;
        scans((16'h1 << 0) | (16'h1 << 3), 5);
        chk("pulses_multi", 8'(pulses), 8'd0);
        scans(16'h1 << 0, 4);
        scans(16'h0, 4);
        chk("pulses_1", 8'(pulses), 8'd1);

        // 'F', short gap, 'F' again; then full release and re-press.
        pulses = 0;
        scans(16'h1 << 13, 4);
        scans(16'h0, 2);
        scans(16'h1 << 13, 2);
        chk("pulses_F_regrab", 8'(pulses), 8'd1);
        scans(16'h0, 4);
        scans(16'h1 << 13, 4);
        scans(16'h0, 4);
        chk("pulses_F", 8'(pulses), 8'd2);

        // Reset in the middle of debouncing '8'.
        pulses = 0;
        scans(16'h1 << 9, 2);
        run_scan(16'h1 << 9, 8);
        do_reset();
        scans(16'h1 << 9, 4);
        scans(16'h0, 4);
        chk("pulses_8", 8'(pulses), 8'd1);

        // Random key patterns held for random runs of scans.
        repeat (30) begin
            case ($urandom_range(0, 3))
                0:       k = 16'h0;
                2:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: k = 16'h1 << $urandom_range(0, 15);
            endcase
            scans(k, $urandom_range(1, 5));
        end
        scans(16'h0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
